// File: rtl/gpio_bank_if.sv
// Peripheral bus bundle for gpio_bank: one-hot port selects, strobes, offset and data.
interface gpio_bank_if #(
    parameter int unsigned NPORTS = 3
) ();
    logic [NPORTS-1:0] sel_i;
    logic              we_i;
    logic              re_i;
    logic [4:0]        addr_i;
    logic [31:0]       wdata_i;
    logic [31:0]       rdata_o;
    logic              ack_o;

    modport master (
        output sel_i,
        output we_i,
        output re_i,
        output addr_i,
        output wdata_i,
        input  rdata_o,
        input  ack_o
    );

    modport slave (
        input  sel_i,
        input  we_i,
        input  re_i,
        input  addr_i,
        input  wdata_i,
        output rdata_o,
        output ack_o
    );
endinterface

// File: rtl/gpio_bank.sv
// NPORTS x WIDTH GPIO bank: direction, atomic set/clear, 2-flop input sync,
// per-bit rise/fall edge interrupts with W1C status and a registered irq.
module gpio_bank #(
    parameter int unsigned NPORTS = 3,
    parameter int unsigned WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    gpio_bank_if.slave              bus,
    input  logic [NPORTS*WIDTH-1:0] gpio_i,
    output logic [NPORTS*WIDTH-1:0] gpio_o,
    output logic [NPORTS*WIDTH-1:0] gpio_oe_o,
    output logic                    irq_o
);

    typedef enum logic [2:0] {
        RegOut    = 3'd0,
        RegDir    = 3'd1,
        RegIn     = 3'd2,
        RegRiseEn = 3'd3,
        RegFallEn = 3'd4,
        RegStatus = 3'd5,
        RegSet    = 3'd6,
        RegClr    = 3'd7
    } reg_e;

    // Packed so that port p lands on bits [p*WIDTH +: WIDTH] when flattened.
    typedef logic [NPORTS-1:0][WIDTH-1:0] bank_t;

    bank_t r_out, r_dir, r_rise_en, r_fall_en, r_status;
    bank_t r_sync1, r_sync2, r_prev;
    bank_t w_out_nxt, w_dir_nxt, w_rise_en_nxt, w_fall_en_nxt, w_status_nxt;
    bank_t w_w1c, w_hw_set;

    logic [NPORTS-1:0] w_sel_lo;
    logic              w_any_sel;
    logic              w_wr;
    logic              w_rd;
    reg_e              w_reg;
    logic [WIDTH-1:0]  w_wdata;
    logic [WIDTH-1:0]  w_rd_val;
    logic [31:0]       r_rdata;
    logic              r_ack;
    logic              r_irq;
    logic              w_unused;

    // Illegal multi-select collapses to the lowest-index selected port.
    assign w_sel_lo  = bus.sel_i & (~bus.sel_i + NPORTS'(1));
    assign w_any_sel = |bus.sel_i;
    assign w_wr      = w_any_sel & bus.we_i;
    assign w_rd      = w_any_sel & bus.re_i;
    assign w_reg     = reg_e'(bus.addr_i[4:2]);
    assign w_wdata   = bus.wdata_i[WIDTH-1:0];
    assign w_unused  = ^{bus.addr_i[1:0], bus.wdata_i};

    assign w_hw_set = (r_sync2 & ~r_prev & r_rise_en) | (~r_sync2 & r_prev & r_fall_en);

    always_comb begin
        w_out_nxt     = r_out;
        w_dir_nxt     = r_dir;
        w_rise_en_nxt = r_rise_en;
        w_fall_en_nxt = r_fall_en;
        w_w1c         = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (w_wr && w_sel_lo[p]) begin
                case (w_reg)
                    RegOut:    w_out_nxt[p]     = w_wdata;
                    RegDir:    w_dir_nxt[p]     = w_wdata;
                    RegRiseEn: w_rise_en_nxt[p] = w_wdata;
                    RegFallEn: w_fall_en_nxt[p] = w_wdata;
                    RegStatus: w_w1c[p]         = w_wdata;
                    RegSet:    w_out_nxt[p]     = r_out[p] | w_wdata;
                    RegClr:    w_out_nxt[p]     = r_out[p] & ~w_wdata;
                    default:   ;
                endcase
            end
        end
        // Hardware set is OR-ed in last so it wins over a simultaneous W1C.
        w_status_nxt = (r_status & ~w_w1c) | w_hw_set;
    end

    // Read mux sees pre-write register values.
    always_comb begin
        w_rd_val = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (w_sel_lo[p]) begin
                case (w_reg)
                    RegOut:    w_rd_val = r_out[p];
                    RegDir:    w_rd_val = r_dir[p];
                    RegIn:     w_rd_val = r_sync2[p];
                    RegRiseEn: w_rd_val = r_rise_en[p];
                    RegFallEn: w_rd_val = r_fall_en[p];
                    RegStatus: w_rd_val = r_status[p];
                    default:   w_rd_val = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out     <= '0;
            r_dir     <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
            r_status  <= '0;
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_prev    <= '0;
            r_rdata   <= '0;
            r_ack     <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_sync1   <= gpio_i;
            r_sync2   <= r_sync1;
            r_prev    <= r_sync2;
            r_out     <= w_out_nxt;
            r_dir     <= w_dir_nxt;
            r_rise_en <= w_rise_en_nxt;
            r_fall_en <= w_fall_en_nxt;
            r_status  <= w_status_nxt;
            r_ack     <= w_any_sel & (bus.we_i | bus.re_i);
            r_rdata   <= w_rd ? 32'(w_rd_val) : '0;
            // Registered from next-state so irq tracks STATUS edge-for-edge.
            r_irq     <= |w_status_nxt;
        end
    end

    assign gpio_o      = r_out;
    assign gpio_oe_o   = r_dir;
    assign irq_o       = r_irq;
    assign bus.rdata_o = r_rdata;
    assign bus.ack_o   = r_ack;

endmodule

// File: tb/tb_gpio_bank.sv
// Directed, table-driven bench for gpio_bank (3 ports x 8 bits).
module tb_gpio_bank;

    localparam int unsigned NP = 3;
    localparam int unsigned W  = 8;

    localparam logic [4:0] A_OUT  = 5'h00;
    localparam logic [4:0] A_DIR  = 5'h04;
    localparam logic [4:0] A_IN   = 5'h08;
    localparam logic [4:0] A_RISE = 5'h0C;
    localparam logic [4:0] A_FALL = 5'h10;
    localparam logic [4:0] A_STAT = 5'h14;
    localparam logic [4:0] A_SET  = 5'h18;
    localparam logic [4:0] A_CLR  = 5'h1C;

    logic              clk;
    logic              rst_n;
    logic [NP*W-1:0]   gpio_i;
    logic [NP*W-1:0]   gpio_o;
    logic [NP*W-1:0]   gpio_oe_o;
    logic              irq_o;

    gpio_bank_if #(.NPORTS(NP)) bif ();

    gpio_bank #(.NPORTS(NP), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bif),
        .gpio_i    (gpio_i),
        .gpio_o    (gpio_o),
        .gpio_oe_o (gpio_oe_o),
        .irq_o     (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  sel;
        logic        we;
        logic        re;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [23:0] exp_out;
        logic [23:0] exp_oe;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    int n_vec;
    int n_bad;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Drive one access at the negedge, sample ack/rdata #1 after the committing posedge.
    task automatic bus_xfer(input logic [2:0] sel, input logic we, input logic re,
                            input logic [4:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rd, output logic ackd);
        @(negedge clk);
        bif.sel_i   = sel;
        bif.we_i    = we;
        bif.re_i    = re;
        bif.addr_i  = addr;
        bif.wdata_i = wdata;
        @(posedge clk);
        #1;
        ackd        = bif.ack_o;
        rd          = bif.rdata_o;
        bif.sel_i   = '0;
        bif.we_i    = 1'b0;
        bif.re_i    = 1'b0;
        bif.addr_i  = '0;
        bif.wdata_i = '0;
    endtask

    task automatic rd_chk(input string nm, input int port, input logic [4:0] addr,
                          input logic [31:0] exp);
        logic [31:0] rd;
        logic        ackd;
        logic [2:0]  sel;
        sel = 3'b001 << port;
        bus_xfer(sel, 1'b0, 1'b1, addr, 32'h0, rd, ackd);
        check({nm, "_ack"}, {31'h0, ackd}, 32'h1);
        check(nm, rd, exp);
    endtask

    task automatic wr(input int port, input logic [4:0] addr, input logic [31:0] wdata);
        logic [31:0] rd;
        logic        ackd;
        logic [2:0]  sel;
        sel = 3'b001 << port;
        bus_xfer(sel, 1'b1, 1'b0, addr, wdata, rd, ackd);
        check("wr_ack", {31'h0, ackd}, 32'h1);
    endtask

    task automatic clocks(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        logic        ackd;

        n_vec = 0;
        n_bad = 0;

        //          sel     we    re    addr    wdata   exp_rd  exp_out    exp_oe
        vecs[0]  = '{3'b010, 1'b1, 1'b0, A_DIR,  32'hFF, 32'h0,  24'h000000, 24'h00FF00};
        vecs[1]  = '{3'b010, 1'b1, 1'b0, A_OUT,  32'hA5, 32'h0,  24'h00A500, 24'h00FF00};
        vecs[2]  = '{3'b010, 1'b1, 1'b0, A_SET,  32'h0A, 32'h0,  24'h00AF00, 24'h00FF00};
        vecs[3]  = '{3'b010, 1'b1, 1'b0, A_CLR,  32'h81, 32'h0,  24'h002E00, 24'h00FF00};
        vecs[4]  = '{3'b010, 1'b0, 1'b1, A_OUT,  32'h0,  32'h2E, 24'h002E00, 24'h00FF00};
        vecs[5]  = '{3'b010, 1'b0, 1'b1, A_DIR,  32'h0,  32'hFF, 24'h002E00, 24'h00FF00};
        vecs[6]  = '{3'b010, 1'b0, 1'b1, A_SET,  32'h0,  32'h0,  24'h002E00, 24'h00FF00};
        vecs[7]  = '{3'b010, 1'b0, 1'b1, A_CLR,  32'h0,  32'h0,  24'h002E00, 24'h00FF00};
        vecs[8]  = '{3'b010, 1'b1, 1'b0, A_IN,   32'hFF, 32'h0,  24'h002E00, 24'h00FF00};
        vecs[9]  = '{3'b010, 1'b0, 1'b1, A_IN,   32'h0,  32'h5A, 24'h002E00, 24'h00FF00};
        vecs[10] = '{3'b001, 1'b1, 1'b0, A_RISE, 32'h01, 32'h0,  24'h002E00, 24'h00FF00};
        vecs[11] = '{3'b001, 1'b1, 1'b0, A_FALL, 32'h02, 32'h0,  24'h002E00, 24'h00FF00};
        vecs[12] = '{3'b001, 1'b0, 1'b1, A_RISE, 32'h0,  32'h01, 24'h002E00, 24'h00FF00};
        vecs[13] = '{3'b001, 1'b0, 1'b1, A_FALL, 32'h0,  32'h02, 24'h002E00, 24'h00FF00};
        vecs[14] = '{3'b100, 1'b1, 1'b1, A_OUT,  32'h33, 32'h0,  24'h332E00, 24'h00FF00};
        vecs[15] = '{3'b100, 1'b0, 1'b1, A_OUT,  32'h0,  32'h33, 24'h332E00, 24'h00FF00};
        vecs[16] = '{3'b100, 1'b1, 1'b1, A_OUT,  32'h0,  32'h33, 24'h002E00, 24'h00FF00};
        vecs[17] = '{3'b110, 1'b1, 1'b0, A_OUT,  32'h77, 32'h0,  24'h007700, 24'h00FF00};
        vecs[18] = '{3'b110, 1'b0, 1'b1, A_OUT,  32'h0,  32'h77, 24'h007700, 24'h00FF00};

        bif.sel_i   = '0;
        bif.we_i    = 1'b0;
        bif.re_i    = 1'b0;
        bif.addr_i  = '0;
        bif.wdata_i = '0;
        gpio_i      = 24'h005A00;
        rst_n       = 1'b0;
        clocks(3);
        @(negedge clk);
        rst_n = 1'b1;

        #1;
        check("rst_ack",   {31'h0, bif.ack_o}, 32'h0);
        check("rst_rdata", bif.rdata_o,        32'h0);
        check("rst_irq",   {31'h0, irq_o},     32'h0);
        check("rst_oe",    {8'h0, gpio_oe_o},  32'h0);
        check("rst_out",   {8'h0, gpio_o},     32'h0);
        clocks(3);

        // Defaults: every offset of every port reads 0 except IN on port 1.
        for (int p = 0; p < NP; p++) begin
            for (int r = 0; r < 8; r++) begin
                logic [4:0] a;
                a = 5'(r * 4);
                rd_chk($sformatf("dflt_p%0d_r%0d", p, r), p, a,
                       (r == 2 && p == 1) ? 32'h5A : 32'h0);
            end
        end
        check("dflt_irq", {31'h0, irq_o}, 32'h0);

        for (int i = 0; i < NVEC; i++) begin
            bus_xfer(vecs[i].sel, vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata, rd, ackd);
            check($sformatf("vec%0d_ack", i), {31'h0, ackd}, 32'h1);
            if (vecs[i].re) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_gpio_o", i), {8'h0, gpio_o}, {8'h0, vecs[i].exp_out});
            check($sformatf("vec%0d_oe", i), {8'h0, gpio_oe_o}, {8'h0, vecs[i].exp_oe});
        end

        // One ack per access, then idle.
        clocks(1);
        #1;
        check("ack_single", {31'h0, bif.ack_o}, 32'h0);
        check("rdata_idle", bif.rdata_o, 32'h0);

        // Back-to-back reads on consecutive cycles.
        @(negedge clk);
        bif.sel_i  = 3'b010;
        bif.re_i   = 1'b1;
        bif.addr_i = A_OUT;
        @(posedge clk);
        #1;
        check("b2b0_ack", {31'h0, bif.ack_o}, 32'h1);
        check("b2b0_rd",  bif.rdata_o,        32'h77);
        bif.addr_i = A_DIR;
        @(posedge clk);
        #1;
        check("b2b1_ack", {31'h0, bif.ack_o}, 32'h1);
        check("b2b1_rd",  bif.rdata_o,        32'hFF);
        bif.sel_i  = '0;
        bif.re_i   = 1'b0;
        bif.addr_i = '0;
        @(posedge clk);
        #1;
        check("b2b_idle", {31'h0, bif.ack_o}, 32'h0);

        // Input sync latency on port 2 bit 3.
        @(negedge clk);
        gpio_i[2*W+3] = 1'b1;
        rd_chk("sync_early", 2, A_IN, 32'h00);
        rd_chk("sync_ready", 2, A_IN, 32'h08);

        // Edge interrupts on port 0: bit1 high first (no fall enable on a rise).
        @(negedge clk);
        gpio_i[1] = 1'b1;
        clocks(4);
        rd_chk("edge_pre_status", 0, A_STAT, 32'h0);
        check("edge_pre_irq", {31'h0, irq_o}, 32'h0);
        @(negedge clk);
        gpio_i[1:0] = 2'b01;
        @(posedge clk);
        #1;
        check("irq_k0", {31'h0, irq_o}, 32'h0);
        @(posedge clk);
        #1;
        check("irq_k1", {31'h0, irq_o}, 32'h0);
        @(posedge clk);
        #1;
        check("irq_k2", {31'h0, irq_o}, 32'h1);
        rd_chk("edge_status", 0, A_STAT, 32'h03);
        @(negedge clk);
        gpio_i[0] = 1'b0;
        clocks(4);
        rd_chk("edge_fall0_ignored", 0, A_STAT, 32'h03);
        wr(0, A_STAT, 32'h01);
        rd_chk("w1c_bit0", 0, A_STAT, 32'h02);
        check("w1c_bit0_irq", {31'h0, irq_o}, 32'h1);
        wr(0, A_RISE, 32'h00);
        rd_chk("en_clear_keeps", 0, A_STAT, 32'h02);
        wr(0, A_RISE, 32'h01);
        wr(0, A_STAT, 32'h02);
        check("w1c_irq_drop", {31'h0, irq_o}, 32'h0);
        rd_chk("w1c_all", 0, A_STAT, 32'h00);

        // Set-vs-clear collision on port 0 bit 0.
        @(negedge clk);
        gpio_i[0] = 1'b1;
        clocks(4);
        @(negedge clk);
        gpio_i[0] = 1'b0;
        clocks(4);
        rd_chk("coll_pre", 0, A_STAT, 32'h01);
        @(negedge clk);
        gpio_i[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        bus_xfer(3'b001, 1'b1, 1'b0, A_STAT, 32'h01, rd, ackd);
        check("coll_ack", {31'h0, ackd}, 32'h1);
        check("coll_irq", {31'h0, irq_o}, 32'h1);
        rd_chk("coll_status", 0, A_STAT, 32'h01);

        // Asynchronous reset during a pending ack.
        @(negedge clk);
        bif.sel_i  = 3'b001;
        bif.re_i   = 1'b1;
        bif.addr_i = A_STAT;
        @(posedge clk);
        #1;
        check("mid_ack_pending", {31'h0, bif.ack_o}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ack",   {31'h0, bif.ack_o}, 32'h0);
        check("mid_rst_rdata", bif.rdata_o,        32'h0);
        check("mid_rst_irq",   {31'h0, irq_o},     32'h0);
        check("mid_rst_oe",    {8'h0, gpio_oe_o},  32'h0);
        check("mid_rst_out",   {8'h0, gpio_o},     32'h0);
        bif.sel_i  = '0;
        bif.re_i   = 1'b0;
        bif.addr_i = '0;
        @(negedge clk);
        rst_n = 1'b1;
        clocks(4);
        rd_chk("post_rst_status", 0, A_STAT, 32'h0);
        rd_chk("post_rst_rise",   0, A_RISE, 32'h0);
        check("post_rst_irq", {31'h0, irq_o}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/gpio_bank.md
# gpio_bank

Parametrised GPIO bank: the successor to the fixed three-port, 8-bit GPIO arrangement. It provides `NPORTS` independent ports of `WIDTH` bits, each with direction control, atomic set/clear, 2-flop input synchronisation and per-bit rising/falling edge interrupts with write-1-to-clear status. It sits on the peripheral data bus behind the address decoder, which supplies one-hot port selects. Tristate pad buffers are instantiated outside this block, at chip top.

## Interface
- `NPORTS`, 3: number of ports, 1..8.
- `WIDTH`, 8: bits per port, 1..32.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `sel_i` in `NPORTS`: one-hot port select from the decoder.
- `we_i` in 1: write strobe, qualified by `sel_i`.
- `re_i` in 1: read strobe, qualified by `sel_i`.
- `addr_i` in 5: byte offset within the port. Bits [4:2] select the register; bits [1:0] are ignored.
- `wdata_i` in 32: write data. Only bits [`WIDTH`-1:0] are used.
- `rdata_o` out 32: read data, zero-extended.
- `ack_o` out 1: transfer complete.
- `gpio_i` in `NPORTS*WIDTH`: pad inputs. Port p occupies bits [p*`WIDTH` +: `WIDTH`].
- `gpio_o` out `NPORTS*WIDTH`: pad output values.
- `gpio_oe_o` out `NPORTS*WIDTH`: pad output enables. 1 = drive the pad.
- `irq_o` out 1: OR of all pending, enabled interrupts.

## Operation
Per-port registers, by word offset:
- 0x00 `OUT` (RW): output data. `gpio_o` = `OUT`.
- 0x04 `DIR` (RW): 1 = output. `gpio_oe_o` = `DIR`.
- 0x08 `IN` (RO): synchronised pad value. Writes are ignored.
- 0x0C `RISE_EN` (RW): rising-edge interrupt enable.
- 0x10 `FALL_EN` (RW): falling-edge interrupt enable.
- 0x14 `STATUS` (RW1C): pending edge flags. Writing 1 clears a bit; writing 0 has no effect.
- 0x18 `SET` (WO): `OUT` |= `wdata`. Reads return 0.
- 0x1C `CLR` (WO): `OUT` &= ~`wdata`. Reads return 0.

Input and interrupt behaviour:
- Input path per bit: sync1 → sync2 (`IN`) → prev. Pads are sampled regardless of `DIR`, so an output pin reads back its own driven value.
- Edge detection: rise = `IN` & ~prev; fall = ~`IN` & prev.
- `STATUS` bit sets when (rise & `RISE_EN`) | (fall & `FALL_EN`).
- Enabling both `RISE_EN` and `FALL_EN` gives any-edge detection.
- Clearing an enable bit does not clear a pending `STATUS` bit.
- `irq_o` = OR over all ports and bits of `STATUS`, driven from flops with no combinational input path.

Bus and priority rules:
- Simultaneous hardware set and W1C of the same `STATUS` bit: the set wins and the bit stays 1.
- More than one `sel_i` bit high is illegal. If it happens, the lowest-index selected port is accessed and the others are untouched.
- A write to an unmapped offset has no effect. The block has no unmapped offsets in [4:2]; this rule covers future extension.
- `we_i` and `re_i` both high: the write happens and the read returns the pre-write value.

## Timing
- Reset values: all registers 0, the sync chain 0, `rdata_o`=0, `ack_o`=0, `irq_o`=0, `gpio_o`=0, `gpio_oe_o`=0 (all pins are inputs out of reset).
- Reset is asynchronous. Asserting `rst_n` mid-transfer aborts the transfer and drops `ack_o` immediately.
- Access: with `sel_i`≠0 and `we_i`|`re_i` in cycle N:
  - register update occurs at the end of cycle N;
  - `ack_o`=1 and `rdata_o` valid in cycle N+1, for exactly one cycle.
- `rdata_o` returns to 0 when `ack_o`=0.
- Back-to-back accesses every cycle are supported, with one ack per access.
- `gpio_o` and `gpio_oe_o` change in the cycle after the write (N+1).
- Pad-to-`IN` latency: a pad edge sampled at clock edge k is visible in `IN` after edge k+1.
- `STATUS` sets at edge k+2, so `irq_o` rises at edge k+2.
- A pulse shorter than one clock may be missed; this is accepted behaviour.
- W1C in cycle N: `STATUS` bit is 0 and `irq_o` falls in cycle N+1, provided no other bit is pending.

## Test plan
- Reset/defaults:
  - Stimulus: after `rst_n` release, read every offset of every port.
  - Required: all reads 0 except `IN`, which reflects `gpio_i` after 2 clocks; `gpio_oe_o`=0; `irq_o`=0; one `ack_o` per access.
- Output path:
  - Stimulus: on port 1, write `DIR`=0xFF, `OUT`=0xA5, `SET` 0x0A, `CLR` 0x81.
  - Required: port 1 slice of `gpio_o` = 0xA5, then 0xAF, then 0x2E; other port slices stay 0.
- Input sync latency:
  - Stimulus: toggle port 2 pad bit 3 from 0 to 1.
  - Required: `IN` bit 3 reads 1 starting two clocks later, not earlier.
- Edge interrupts:
  - Stimulus: port 0 `RISE_EN`=0x01, `FALL_EN`=0x02; drive pad bit0 0→1 and bit1 1→0, plus bit0 1→0.
  - Required: `STATUS`=0x03 and `irq_o`=1; the bit0 falling edge sets nothing. W1C 0x01 leaves `STATUS`=0x02; W1C 0x02 drops `irq_o` the next cycle.
- Set-vs-clear collision:
  - Stimulus: W1C `STATUS` bit0 in the same cycle a new enabled rising edge reaches bit0.
  - Required: `STATUS` bit0 stays 1 and `irq_o` stays 1.
- Reset mid-operation:
  - Stimulus: assert `rst_n` low during a pending ack with `STATUS`≠0.
  - Required: `ack_o`, `irq_o`, `gpio_oe_o` and `STATUS` are 0 without waiting for a clock edge.
